// File: rtl/chimera_pkg.sv
// Shared cluster-domain constants and types: cluster count, power-sequencer timing, command and FSM encodings.
// Pure declarations; no latency or backpressure of its own.
package chimera_pkg;

  localparam int unsigned ExtClusters         = 5;
  localparam int unsigned ClusterSettleCycles = 8;
  localparam int unsigned ClusterWakeDelay    = 4;

  typedef enum logic [1:0] {
    CluPowerUp   = 2'd0,
    CluPowerDown = 2'd1,
    CluWake      = 2'd2,
    CluRsvd      = 2'd3
  } clu_cmd_op_e;

  typedef enum logic [2:0] {
    SeqIdle    = 3'd0,
    SeqSettle  = 3'd1,
    SeqRelease = 3'd2,
    SeqWake    = 3'd3,
    SeqDrain   = 3'd4,
    SeqGate    = 3'd5
  } clu_seq_state_e;

  // Wide enough to hold the longer of the two phase lengths.
  function automatic int unsigned seq_cnt_width(input int unsigned settle, input int unsigned wake);
    int unsigned longest;
    longest = (settle > wake) ? settle : wake;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/chimera_clu_seq_cnt.sv
// Loadable down-counter timing each sequencer phase; load takes effect next cycle, counts down to 0 and stops there.
// No handshake: zero_o is a plain level read by the sequencer FSM.
module chimera_clu_seq_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Serialised cluster power sequencer: clock on -> reset release -> wake, and reset assert -> clock off; outputs registered.
// One command in flight; cmd_ready_o is low for the whole sequence, illegal commands are accepted and flagged next cycle.
module chimera_clu_pwr_seq
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters  = ExtClusters,
  parameter int unsigned SettleCycles = ClusterSettleCycles,
  parameter int unsigned WakeDelay    = ClusterWakeDelay,
  parameter int unsigned IdxW         = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [IdxW-1:0]        cmd_clu_i,
  input  logic [1:0]             cmd_op_i,
  input  logic                   cmd_bypass_i,
  output logic                   cmd_err_o,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] widemem_bypass_o,
  output logic [NumClusters-1:0] clu_wake_o,
  output logic [NumClusters-1:0] clu_on_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = seq_cnt_width(SettleCycles, WakeDelay);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] WakeLoad   = CntW'(WakeDelay - 1);

  if (SettleCycles < 1) begin : g_chk_settle
    $error("chimera_clu_pwr_seq: SettleCycles must be >= 1");
  end
  if (WakeDelay < 1) begin : g_chk_wake
    $error("chimera_clu_pwr_seq: WakeDelay must be >= 1");
  end
  if (NumClusters < 1) begin : g_chk_num
    $error("chimera_clu_pwr_seq: NumClusters must be >= 1");
  end

  clu_seq_state_e state_q, state_d;
  clu_cmd_op_e    cmd_op;

  logic                   accept;
  logic                   cmd_oob;
  logic                   cmd_on;
  logic                   cmd_illegal;
  logic [NumClusters-1:0] cmd_oh;
  logic [NumClusters-1:0] tgt_oh;
  logic [IdxW-1:0]        tgt_q;

  logic                   cnt_load;
  logic [CntW-1:0]        cnt_value;
  logic                   cnt_zero;

  logic                   up_start;
  logic                   dn_start;
  logic                   rel_start;
  logic                   gate_start;

  logic [NumClusters-1:0] clk_en_q;
  logic [NumClusters-1:0] rst_n_q;
  logic [NumClusters-1:0] bypass_q;
  logic [NumClusters-1:0] on_q;
  logic                   err_q;

  assign cmd_op  = clu_cmd_op_e'(cmd_op_i);
  assign accept  = cmd_valid_i && (state_q == SeqIdle);
  assign cmd_oob = (32'(cmd_clu_i) >= NumClusters);
  // Out-of-range indices shift the bit out, so the masks are simply empty.
  assign cmd_oh  = NumClusters'(1) << cmd_clu_i;
  assign tgt_oh  = NumClusters'(1) << tgt_q;
  assign cmd_on  = |(on_q & cmd_oh);

  always_comb begin
    cmd_illegal = 1'b0;
    if (cmd_oob) begin
      cmd_illegal = 1'b1;
    end else begin
      case (cmd_op)
        CluPowerUp:   cmd_illegal = cmd_on;
        CluPowerDown: cmd_illegal = !cmd_on;
        CluWake:      cmd_illegal = !cmd_on;
        default:      cmd_illegal = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SeqIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SeqIdle: begin
        if (accept && !cmd_illegal) begin
          case (cmd_op)
            CluPowerUp:   state_d = SeqSettle;
            CluPowerDown: state_d = SeqDrain;
            CluWake:      state_d = SeqWake;
            default:      state_d = SeqIdle;
          endcase
        end
      end
      SeqSettle:  if (cnt_zero) state_d = SeqRelease;
      SeqRelease: if (cnt_zero) state_d = SeqWake;
      SeqWake:    state_d = SeqIdle;
      SeqDrain:   if (cnt_zero) state_d = SeqGate;
      SeqGate:    state_d = SeqIdle;
      default:    state_d = SeqIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    cmd_ready_o = (state_q == SeqIdle);
    busy_o      = (state_q != SeqIdle);
    clu_wake_o  = (state_q == SeqWake) ? tgt_oh : '0;
    up_start    = (state_q == SeqIdle)   && (state_d == SeqSettle);
    dn_start    = (state_q == SeqIdle)   && (state_d == SeqDrain);
    rel_start   = (state_q == SeqSettle) && (state_d == SeqRelease);
    gate_start  = (state_q == SeqDrain)  && (state_d == SeqGate);
    cnt_load    = up_start || dn_start || rel_start;
    cnt_value   = rel_start ? WakeLoad : SettleLoad;
  end

  chimera_clu_seq_cnt #(
    .Width (CntW)
  ) i_cnt (
    .clk_i   (soc_clk_i),
    .rst_ni  (rst_ni),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .zero_o  (cnt_zero)
  );

  // Per-cluster control state; only the targeted cluster's bits ever move.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q <= '0;
      rst_n_q  <= '0;
      bypass_q <= '0;
      on_q     <= '0;
      err_q    <= 1'b0;
      tgt_q    <= '0;
    end else begin
      err_q <= accept && cmd_illegal;
      if (accept) begin
        tgt_q <= cmd_clu_i;
      end
      if (up_start) begin
        clk_en_q <= clk_en_q | cmd_oh;
        bypass_q <= (bypass_q & ~cmd_oh) | (cmd_bypass_i ? cmd_oh : '0);
      end
      if (dn_start) begin
        rst_n_q <= rst_n_q & ~cmd_oh;
      end
      if (rel_start) begin
        rst_n_q <= rst_n_q | tgt_oh;
        on_q    <= on_q | tgt_oh;
      end
      if (gate_start) begin
        clk_en_q <= clk_en_q & ~tgt_oh;
        on_q     <= on_q & ~tgt_oh;
      end
    end
  end

  assign clu_clk_en_o     = clk_en_q;
  assign clu_rst_no       = rst_n_q;
  assign widemem_bypass_o = bypass_q;
  assign clu_on_o         = on_q;
  assign cmd_err_o        = err_q;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Bench for chimera_clu_pwr_seq: a spec-level model pushes per-cycle expected output snapshots, each scenario pops and compares them.
module tb_chimera_clu_pwr_seq;
  import chimera_pkg::*;

  localparam int N      = 5;
  localparam int SETTLE = 8;
  localparam int WDELAY = 4;

  typedef logic [5*N+2:0] snap_t;

  logic         soc_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_clu = '0;
  logic [1:0]   cmd_op  = '0;
  logic         cmd_bypass = 1'b0;
  logic         cmd_err;
  logic [N-1:0] clk_en, clu_rst_n, bypass, wake, on;
  logic         busy;

  always #5 soc_clk = ~soc_clk;

  chimera_clu_pwr_seq dut (
    .soc_clk_i        (soc_clk),
    .rst_ni           (rst_n),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_clu_i        (cmd_clu),
    .cmd_op_i         (cmd_op),
    .cmd_bypass_i     (cmd_bypass),
    .cmd_err_o        (cmd_err),
    .clu_clk_en_o     (clk_en),
    .clu_rst_no       (clu_rst_n),
    .widemem_bypass_o (bypass),
    .clu_wake_o       (wake),
    .clu_on_o         (on),
    .busy_o           (busy)
  );

  snap_t        sb[$];
  logic [N-1:0] m_clk_en = '0, m_rst_n = '0, m_byp = '0, m_on = '0;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic snap_t mk(input logic [N-1:0] ce, rn, bp, wk, o,
                               input logic bsy, rdy, err);
    return {ce, rn, bp, wk, o, bsy, rdy, err};
  endfunction

  function automatic snap_t observe();
    return {clk_en, clu_rst_n, bypass, wake, on, busy, cmd_ready, cmd_err};
  endfunction

  // Model of the sequencer's visible behaviour; pushes one snapshot per cycle from t1 to the idle cycle.
  task automatic expect_cmd(input int clu, input logic [1:0] op, input logic byp);
    logic [N-1:0] oh;
    logic         illegal;
    oh = (clu < N) ? (N'(1) << clu) : '0;
    illegal = (clu >= N) || (op == 2'd3) ||
              (op == 2'd0 && |(m_on & oh)) || (op != 2'd0 && !(|(m_on & oh)));
    if (illegal) begin
      sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b0, 1'b1, 1'b1));
    end else if (op == 2'd0) begin
      m_clk_en = m_clk_en | oh;
      m_byp    = (m_byp & ~oh) | (byp ? oh : '0);
      repeat (SETTLE) sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b1, 1'b0, 1'b0));
      m_rst_n = m_rst_n | oh;
      m_on    = m_on | oh;
      repeat (WDELAY) sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk(m_clk_en, m_rst_n, m_byp, oh, m_on, 1'b1, 1'b0, 1'b0));
    end else if (op == 2'd1) begin
      m_rst_n = m_rst_n & ~oh;
      repeat (SETTLE) sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b1, 1'b0, 1'b0));
      m_clk_en = m_clk_en & ~oh;
      m_on     = m_on & ~oh;
      sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b1, 1'b0, 1'b0));
    end else begin
      sb.push_back(mk(m_clk_en, m_rst_n, m_byp, oh, m_on, 1'b1, 1'b0, 1'b0));
    end
    sb.push_back(mk(m_clk_en, m_rst_n, m_byp, '0, m_on, 1'b0, 1'b1, 1'b0));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of t1.
  task automatic drive_cmd(input logic [2:0] clu, input logic [1:0] op, input logic byp);
    cmd_valid  = 1'b1;
    cmd_clu    = clu;
    cmd_op     = op;
    cmd_bypass = byp;
    @(posedge soc_clk);
    @(negedge soc_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    snap_t obs, exp;
    exp = mk('0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge soc_clk);
    obs = observe();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", obs, exp);
    end
    rst_n = 1'b1;
    @(negedge soc_clk);
    obs = observe();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_released: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_powerup();
    snap_t obs, exp;
    int    k = 0;
    expect_cmd(2, 2'd0, 1'b1);
    drive_cmd(3'd2, 2'd0, 1'b1);
    while (sb.size() != 0) begin
      k++;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL powerup t%0d: got %h expected %h", k, obs, exp);
      end
      @(negedge soc_clk);
    end
  endtask

  task automatic test_illegal();
    snap_t      obs, exp;
    int         clus[6] = '{0, 7, 1, 2, 0, 6};
    logic [1:0] ops[6]  = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      expect_cmd(clus[i], ops[i], 1'b1);
      drive_cmd(3'(clus[i]), ops[i], 1'b1);
      while (sb.size() != 0) begin
        exp = sb.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL illegal[%0d] clu=%0d op=%0d: got %h expected %h", i, clus[i], ops[i], obs, exp);
        end
        @(negedge soc_clk);
      end
    end
  endtask

  task automatic test_wake();
    snap_t obs, exp;
    int    k = 0;
    expect_cmd(1, 2'd0, 1'b0);
    expect_cmd(1, 2'd2, 1'b0);
    drive_cmd(3'd1, 2'd0, 1'b0);
    while (sb.size() != 0) begin
      k++;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL wake t%0d: got %h expected %h", k, obs, exp);
      end
      // The wake command is issued once power-up has returned to idle.
      if (k == 2 * 0 + SETTLE + WDELAY + 2) begin
        cmd_valid = 1'b1; cmd_clu = 3'd1; cmd_op = 2'd2; cmd_bypass = 1'b0;
        @(posedge soc_clk);
        @(negedge soc_clk);
        cmd_valid = 1'b0;
      end else begin
        @(negedge soc_clk);
      end
    end
  endtask

  task automatic test_powerdown();
    snap_t obs, exp;
    int    k = 0;
    expect_cmd(2, 2'd1, 1'b0);
    drive_cmd(3'd2, 2'd1, 1'b0);
    while (sb.size() != 0) begin
      k++;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL powerdown t%0d: got %h expected %h", k, obs, exp);
      end
      @(negedge soc_clk);
    end
    n_checks++;
    if (bypass[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL powerdown_bypass_hold: got %b expected 1", bypass[2]);
    end
  endtask

  task automatic test_back_to_back();
    snap_t obs, exp;
    int    k = 0;
    expect_cmd(0, 2'd0, 1'b1);
    expect_cmd(1, 2'd1, 1'b0);
    cmd_valid = 1'b1; cmd_clu = 3'd0; cmd_op = 2'd0; cmd_bypass = 1'b1;
    @(posedge soc_clk);
    @(negedge soc_clk);
    // Second command waits on ready while the first sequence runs.
    cmd_clu = 3'd1; cmd_op = 2'd1; cmd_bypass = 1'b0;
    while (sb.size() != 0) begin
      k++;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back t%0d: got %h expected %h", k, obs, exp);
      end
      if (k == SETTLE + WDELAY + 3) cmd_valid = 1'b0;
      @(negedge soc_clk);
    end
  endtask

  task automatic test_reset_mid();
    snap_t obs, exp;
    int    k = 0;
    expect_cmd(3, 2'd0, 1'b0);
    drive_cmd(3'd3, 2'd0, 1'b0);
    for (int i = 0; i < SETTLE + 2; i++) begin
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_pre t%0d: got %h expected %h", i + 1, obs, exp);
      end
      @(negedge soc_clk);
    end
    sb.delete();
    rst_n = 1'b0;
    #1;
    m_clk_en = '0; m_rst_n = '0; m_byp = '0; m_on = '0;
    exp = mk('0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", obs, exp);
    end
    @(negedge soc_clk);
    rst_n = 1'b1;
    @(negedge soc_clk);
    expect_cmd(3, 2'd0, 1'b1);
    drive_cmd(3'd3, 2'd0, 1'b1);
    while (sb.size() != 0) begin
      k++;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_rerun t%0d: got %h expected %h", k, obs, exp);
      end
      @(negedge soc_clk);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_illegal();
    test_wake();
    test_powerdown();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chimera_clu_pwr_seq.md
Name: chimera_clu_pwr_seq

Overview:
Central sequencer that brings Snitch-type clusters of the cluster domain up and down, one command at a time. It drives each cluster's clock enable, active-low reset, wide-memory bypass select and a one-cycle wake pulse that is OR-ed into the cluster harts' msip.
It sits in the SoC clock domain between the SoC control registers, which issue commands, and the cluster domain's per-cluster clock/reset/bypass inputs.
It serialises all commands and enforces the ordering: clock on, then reset release, then wake; and reset assert, then clock off.

Parameters:
NumClusters, 5 (ExtClusters), number of controlled clusters
SettleCycles, 8, cycles the clock runs with reset held, on both power-up and power-down; must be >=1
WakeDelay, 4, cycles between reset release and the wake pulse; must be >=1

Ports:
soc_clk_i  in  1  SoC clock
rst_ni  in  1  asynchronous reset, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_clu_i  in  $clog2(NumClusters)  target cluster index
cmd_op_i  in  2  operation, type clu_cmd_op_e
cmd_bypass_i  in  1  widemem bypass value applied on power-up
cmd_err_o  out  1  one-cycle pulse: last accepted command was illegal
clu_clk_en_o  out  NumClusters  per-cluster clock enable
clu_rst_no  out  NumClusters  per-cluster reset, active-low
widemem_bypass_o  out  NumClusters  per-cluster wide-memory bypass
clu_wake_o  out  NumClusters  one-cycle wake pulse (to msip)
clu_on_o  out  NumClusters  cluster powered and out of reset
busy_o  out  1  sequencer is not in IDLE

Behaviour:
- Reset (async, any time, including mid-sequence): FSM goes to IDLE and the counter clears. All outputs are 0: clu_clk_en_o, clu_rst_no (all clusters held in reset), widemem_bypass_o, clu_wake_o, clu_on_o, cmd_err_o, busy_o. No partially executed command is retained.
- cmd_ready_o = (state==IDLE). Requesters hold cmd_* stable from valid until ready. Accepting a command latches index, op and bypass.
- FSM states: IDLE, SETTLE, RELEASE, WAKE, DRAIN, GATE.
- Illegal commands are accepted but have no effect. The FSM stays in IDLE and cmd_err_o pulses in the cycle after accept. Illegal means any of:
  - cmd_clu_i >= NumClusters
  - op == reserved (2'd3)
  - PowerUp with clu_on_o[c]=1
  - PowerDown with clu_on_o[c]=0
  - Wake with clu_on_o[c]=0
- PowerUp, with the accept edge at t0:
  - t1..t(SettleCycles): SETTLE. clu_clk_en_o[c]=1 and widemem_bypass_o[c]=latched bypass, both from t1. Reset stays low.
  - Next WakeDelay cycles: RELEASE. clu_rst_no[c]=1 and clu_on_o[c]=1, both from the first RELEASE cycle.
  - Next cycle: WAKE. clu_wake_o[c]=1 for exactly one cycle.
  - Then IDLE.
- Wake: IDLE -> WAKE (1 cycle pulse) -> IDLE.
- PowerDown:
  - DRAIN for SettleCycles cycles. clu_rst_no[c]=0 from the first DRAIN cycle; the clock keeps running so the reset propagates.
  - GATE for 1 cycle. clu_clk_en_o[c]=0 and clu_on_o[c]=0 from GATE.
  - Then IDLE. widemem_bypass_o[c] holds its value; it changes only on the next PowerUp.
- Non-target clusters' outputs never change during a sequence.
- Counter: down-counter of width $clog2(max(SettleCycles,WakeDelay)+1). Loaded with N-1 on state entry; the state exits when the counter reaches 0. There is no wrap.
- busy_o = (state != IDLE).
- Elaboration assertions: SettleCycles>=1, WakeDelay>=1, NumClusters>=1.

Decomposition:
- chimera_pkg gains:
  - typedef enum logic [1:0] clu_cmd_op_e: CluPowerUp=0, CluPowerDown=1, CluWake=2, CluRsvd=3
  - localparams ClusterSettleCycles and ClusterWakeDelay
- One sub-module, chimera_clu_seq_cnt: a loadable down-counter with load_i, value_i and zero_o.

Test Plan:
- Out of reset -> all outputs 0, cmd_ready_o=1, all clu_rst_no=0, all clu_clk_en_o=0.
- PowerUp clu=2 bypass=1 (Settle=8, Wake=4), accepted at t0 -> clk_en[2]=1 and bypass[2]=1 at t1; rst_no[2]=1 at t9; wake[2] pulse at t13 only; ready at t14; other clusters unchanged.
- PowerDown clu=2 after up, accepted at t0 -> rst_no[2]=0 at t1; clk_en[2]=0 and on[2]=0 at t9; ready at t10; bypass[2] still 1.
- Illegal commands, each accepted with no output change and err pulse at t1:
  - Wake clu=0 while off
  - PowerUp clu=7
  - op=3
- Wake clu=1 while on -> wake[1]=1 at t1 only; ready at t2.
- Assert rst_ni in the middle of the RELEASE phase -> all outputs 0 immediately. A PowerUp after deassert runs a full sequence from SETTLE.
